// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl -- line-fill initiator for the two-level instruction cache.
//
// When the fetch stage reports an L1 miss, the controller probes L2 with the
// line-aligned miss address. On an L2 hit the 515-bit line {fault,data} is
// copied into L1. On an L2 miss the 64-byte line is burst from the system bus
// as four 128-bit beats written into L2. L2 is then re-probed and the line is
// loaded into L1.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   l1_hit, l1_missadr       fetch-stage L1 tag result and miss address
//   l2_hit, l2_o             L2 tag result / line, valid the cycle after l2_adr
//   l2_adr                   L2 lookup/write address (line aligned)
//   l2_wr,l2_cnt,l2_dat,
//   l2_exv,l2_err            L2 beat write port (one strobe per bus beat)
//   l1_wr, l1_wadr, l1_dat   L1 line write port
//   nxt                      one-cycle pulse advancing the replacement LFSRs
//   busy                     fill in progress
//   cyc_o,stb_o,adr_o,
//   ack_i,err_i,exv_i,dat_i  system bus master interface
module icache_fill_ctrl #(
  parameter int AMSB     = 63,
  parameter int pTimeout = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          l1_hit,
  input  logic [AMSB:0] l1_missadr,
  input  logic          l2_hit,
  input  logic [514:0]  l2_o,
  output logic [AMSB:0] l2_adr,
  output logic          l2_wr,
  output logic [2:0]    l2_cnt,
  output logic [127:0]  l2_dat,
  output logic          l2_exv,
  output logic          l2_err,
  output logic          l1_wr,
  output logic [AMSB:0] l1_wadr,
  output logic [514:0]  l1_dat,
  output logic          nxt,
  output logic          busy,
  output logic          cyc_o,
  output logic          stb_o,
  output logic [AMSB:0] adr_o,
  input  logic          ack_i,
  input  logic          err_i,
  input  logic          exv_i,
  input  logic [127:0]  dat_i
);

  localparam int TW = $clog2(pTimeout + 1);
  localparam logic [AMSB:0] LINE_MASK = ~((AMSB + 1)'(63));

  typedef enum logic [2:0] {
    IDLE, L2_RD, L2_CHK, BUS, SETTLE, L1_WR, L1_WAIT, DONE
  } state_t;

  state_t        state_q;
  logic [AMSB:0] la_q;
  logic [1:0]    beat_q;
  logic [TW-1:0] to_cnt_q;
  logic [1:0]    wait_q;
  logic          refill_q;

  logic          l2_wr_q;
  logic [2:0]    l2_cnt_q;
  logic [127:0]  l2_dat_q;
  logic          l2_exv_q;
  logic          l2_err_q;
  logic          l1_wr_q;
  logic [514:0]  l1_dat_q;
  logic          nxt_q;
  logic          busy_q;
  logic          cyc_q;
  logic          stb_q;
  logic [AMSB:0] adr_q;

  logic [AMSB:0] la_d;
  logic [AMSB:0] beat_adr_d;
  logic          timeout_d;
  logic          term_d;
  logic          beat_err_d;

  assign la_d       = l1_missadr & LINE_MASK;
  assign beat_adr_d = la_q + {{(AMSB - 5){1'b0}}, beat_q, 4'b0000};
  // Counter holds the number of strobe cycles already spent on this beat;
  // the beat is forced complete in its pTimeout-th strobe cycle.
  assign timeout_d  = (to_cnt_q == TW'(pTimeout - 1));
  assign term_d     = ack_i | err_i | timeout_d;
  // ack_i together with err_i counts as an error beat.
  assign beat_err_d = err_i | timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      la_q     <= '0;
      beat_q   <= '0;
      to_cnt_q <= '0;
      wait_q   <= '0;
      refill_q <= 1'b0;
      l2_wr_q  <= 1'b0;
      l2_cnt_q <= '0;
      l2_dat_q <= '0;
      l2_exv_q <= 1'b0;
      l2_err_q <= 1'b0;
      l1_wr_q  <= 1'b0;
      l1_dat_q <= '0;
      nxt_q    <= 1'b0;
      busy_q   <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      adr_q    <= '0;
    end else begin
      l2_wr_q <= 1'b0;
      l1_wr_q <= 1'b0;
      nxt_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!l1_hit) begin
            la_q    <= la_d;
            busy_q  <= 1'b1;
            state_q <= L2_RD;
          end
        end
        L2_RD: begin
          // l2_adr already carries the line address; l2_hit answers next cycle.
          state_q <= L2_CHK;
        end
        L2_CHK: begin
          // A second miss after our own refill still loads L1 from l2_o,
          // otherwise a line that never sticks in L2 would loop forever.
          if (l2_hit || refill_q) begin
            l1_dat_q <= l2_o;
            l1_wr_q  <= 1'b1;
            state_q  <= L1_WR;
          end else begin
            beat_q   <= '0;
            to_cnt_q <= '0;
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            adr_q    <= la_q;
            state_q  <= BUS;
          end
        end
        BUS: begin
          if (stb_q) begin
            if (term_d) begin
              l2_dat_q <= beat_err_d ? '0 : dat_i;
              l2_err_q <= beat_err_d;
              l2_exv_q <= exv_i;
              l2_cnt_q <= {1'b0, beat_q};
              l2_wr_q  <= 1'b1;
              stb_q    <= 1'b0;
              to_cnt_q <= '0;
              if (beat_q == 2'd3) begin
                cyc_q    <= 1'b0;
                refill_q <= 1'b1;
              end else begin
                beat_q <= beat_q + 2'd1;
              end
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
          end else if (cyc_q) begin
            // Strobe-low gap after a termination; start the next beat.
            stb_q <= 1'b1;
            adr_q <= beat_adr_d;
          end else begin
            // Gap after the last beat (its l2_wr pulses here); bus is released.
            wait_q  <= 2'd2;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          // Lets the L2 write pipeline and registered read catch up before
          // the re-probe.
          if (wait_q == 2'd0) begin
            state_q <= L2_RD;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        L1_WR: begin
          wait_q  <= 2'd1;
          state_q <= L1_WAIT;
        end
        L1_WAIT: begin
          // Covers the L1 tag write and the delayed data write.
          if (wait_q == 2'd0) begin
            nxt_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        DONE: begin
          // l1_hit is not looked at here: it may still show the stale miss.
          refill_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign l2_adr  = la_q;
  assign l1_wadr = la_q;
  assign l2_wr   = l2_wr_q;
  assign l2_cnt  = l2_cnt_q;
  assign l2_dat  = l2_dat_q;
  assign l2_exv  = l2_exv_q;
  assign l2_err  = l2_err_q;
  assign l1_wr   = l1_wr_q;
  assign l1_dat  = l1_dat_q;
  assign nxt     = nxt_q;
  assign busy    = busy_q;
  assign cyc_o   = cyc_q;
  assign stb_o   = stb_q;
  assign adr_o   = adr_q;

endmodule
